// File: rtl/curve_lut_sched_if.sv
// Lookup request/response bundle for curve_lut_sched: two requesters, each with
// a valid/ready request channel and a strobe-only response channel.
interface curve_lut_sched_if #(
  parameter int WIDTH = 16
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_data;
  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_data;
  logic             rsp0_valid;
  logic [WIDTH-1:0] rsp0_data;
  logic             rsp1_valid;
  logic [WIDTH-1:0] rsp1_data;

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_data, rsp1_valid, rsp1_data
  );

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_data, rsp1_valid, rsp1_data
  );
endinterface

// File: rtl/curve_lut_sched.sv
// Curve lookup table shared by two requesters: loaded sequentially in LOAD,
// then served one clamped lookup per cycle in RUN under round-robin arbitration.
module curve_lut_sched #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_load_start_i,
  input  logic             cfg_wen_i,
  input  logic [WIDTH-1:0] cfg_wdata_i,
  output logic             table_valid_o,
  curve_lut_sched_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_e;

  state_e           state_q;
  logic [7:0]       loadAddr_q;
  logic             tableValid_q;
  logic [WIDTH-1:0] table_q [DEPTH];
  logic             prio_q;
  logic             rsp0Valid_q;
  logic             rsp1Valid_q;
  logic [WIDTH-1:0] rsp0Data_q;
  logic [WIDTH-1:0] rsp1Data_q;

  logic             grantEn;
  logic             gnt0;
  logic             gnt1;
  logic             tblWe;
  logic [7:0]       tblWaddr;
  int               lookupIdx;
  logic [7:0]       lookupAddr;

  // prio_q high means requester 1 wins the next contention.
  always_comb begin
    grantEn = (state_q == RUN) && !cfg_load_start_i;
    gnt0    = grantEn && bus.req0_valid && (!bus.req1_valid || !prio_q);
    gnt1    = grantEn && bus.req1_valid && (!bus.req0_valid || prio_q);
  end

  // Only one grant per cycle, so a single shared clamp/read port suffices.
  always_comb begin
    lookupIdx = gnt1 ? int'($signed(bus.req1_data)) : int'($signed(bus.req0_data));
    if (lookupIdx < 0) begin
      lookupAddr = '0;
    end else if (lookupIdx > DEPTH - 1) begin
      lookupAddr = 8'(DEPTH - 1);
    end else begin
      lookupAddr = 8'(lookupIdx);
    end
  end

  always_comb begin
    tblWe    = (state_q == LOAD) && cfg_wen_i;
    tblWaddr = cfg_load_start_i ? 8'd0 : loadAddr_q;
  end

  // Table storage is deliberately not reset; it is only trusted after a full load.
  always_ff @(posedge clk) begin
    if (tblWe) begin
      table_q[tblWaddr] <= cfg_wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      loadAddr_q   <= '0;
      tableValid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cfg_load_start_i) begin
            state_q    <= LOAD;
            loadAddr_q <= '0;
          end
        end
        LOAD: begin
          if (cfg_load_start_i) begin
            loadAddr_q <= cfg_wen_i ? 8'd1 : 8'd0;
          end else if (cfg_wen_i) begin
            if (loadAddr_q == 8'(DEPTH - 1)) begin
              state_q      <= RUN;
              tableValid_q <= 1'b1;
              loadAddr_q   <= '0;
            end else begin
              loadAddr_q <= loadAddr_q + 8'd1;
            end
          end
        end
        RUN: begin
          if (cfg_load_start_i) begin
            state_q      <= LOAD;
            tableValid_q <= 1'b0;
            loadAddr_q   <= '0;
          end
        end
        default: begin
          state_q      <= IDLE;
          tableValid_q <= 1'b0;
          loadAddr_q   <= '0;
        end
      endcase
    end
  end

  // Responses are registered independently of state so an accept in the last
  // RUN cycle still completes after the switch to LOAD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp0Valid_q <= 1'b0;
      rsp1Valid_q <= 1'b0;
      rsp0Data_q  <= '0;
      rsp1Data_q  <= '0;
      prio_q      <= 1'b0;
    end else begin
      rsp0Valid_q <= gnt0;
      rsp1Valid_q <= gnt1;
      if (gnt0) begin
        rsp0Data_q <= table_q[lookupAddr];
        prio_q     <= 1'b1;
      end
      if (gnt1) begin
        rsp1Data_q <= table_q[lookupAddr];
        prio_q     <= 1'b0;
      end
    end
  end

  assign table_valid_o  = tableValid_q;
  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;
  assign bus.rsp0_valid = rsp0Valid_q;
  assign bus.rsp1_valid = rsp1Valid_q;
  assign bus.rsp0_data  = rsp0Data_q;
  assign bus.rsp1_data  = rsp1Data_q;

endmodule

// File: doc/curve_lut_sched.md
CURVE_LUT_SCHED -- requirements
Module: curve_lut_sched

Interface
REQ-001 Parameter WIDTH, default 16, SHALL set the data width of requests, responses and table entries.
REQ-002 Parameter DEPTH, default 255, SHALL set the number of curve table entries; the address width is 8 bits.
REQ-003 The block has one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 cfg_load_start  in  1  pulse that begins a table load at address 0.
REQ-007 cfg_wen  in  1  table write strobe, honoured only in LOAD.
REQ-008 cfg_wdata  in  WIDTH  table entry written at the current load address.
REQ-009 table_valid  out  1  high in RUN only.
REQ-010 req0_valid, req1_valid  in  1  lookup request from requester 0 or 1.
REQ-011 req0_data, req1_data  in  WIDTH  signed lookup index.
REQ-012 req0_ready, req1_ready  out  1  grant; a request is accepted when valid and ready are both high.
REQ-013 rsp0_valid, rsp1_valid  out  1  one-cycle response strobe, with no backpressure.
REQ-014 rsp0_data, rsp1_data  out  WIDTH  table entry for the accepted index.

Function
REQ-015 FSM states SHALL be IDLE, LOAD and RUN.
REQ-016 Transitions:
- IDLE->LOAD on cfg_load_start.
- LOAD->RUN on the cycle that performs write number DEPTH (address DEPTH-1).
- RUN->LOAD on cfg_load_start.
- No other transitions.
REQ-017 In LOAD, each cfg_wen SHALL write cfg_wdata to table[load_addr], then increment load_addr; load_addr resets to 0 on entry to LOAD.
REQ-018 cfg_load_start asserted during LOAD SHALL restart the load at address 0; a cfg_wen in the same cycle writes address 0, so the next write goes to address 1.
REQ-019 cfg_wen outside LOAD SHALL be ignored, and the table is left unchanged.
REQ-020 req0_ready and req1_ready SHALL be 0 outside RUN, and 0 in a RUN cycle in which cfg_load_start is high.
REQ-021 At most one request SHALL be granted per cycle, and a ready is high only toward a requester whose valid is high (combinational from valid and the priority pointer).
REQ-022 Arbitration SHALL be round-robin.
- With both requesters valid, the requester not granted last wins.
- With one valid, it wins.
- The pointer updates only on acceptance.
REQ-023 The round-robin pointer SHALL reset so that requester 0 wins the first contention.
REQ-024 The index SHALL be clamped as a signed value: negative -> 0; greater than DEPTH-1 -> DEPTH-1; otherwise unchanged.
REQ-025 For an acceptance at edge T, rspN_valid SHALL be high for exactly the cycle after T, with rspN_data = table[clamped index] as it was before edge T; latency is 1 cycle.
REQ-026 rspN_data SHALL hold its last value while rspN_valid is low.
REQ-027 A response for a request accepted in the last RUN cycle SHALL still be issued in the cycle after, even if the state is then LOAD.
REQ-028 Throughput SHALL be one lookup per cycle in total, shared between the two requesters.

Reset
REQ-029 On rst_n low, the following SHALL take effect asynchronously:
- state = IDLE, table_valid = 0, load_addr = 0;
- rsp0_valid = rsp1_valid = 0, rsp0_data = rsp1_data = 0;
- the round-robin pointer favours requester 0.
REQ-030 Table contents SHALL NOT be cleared by reset, but are unusable until a full load completes.
REQ-031 Reset asserted mid-LOAD SHALL abandon the load; after release, the state is IDLE.

Verification
REQ-032 Load table[i] = i*2 for i = 0..254, then req0 index 10 -> rsp0_valid one cycle later with rsp0_data = 20, and table_valid = 1 after write 255.
REQ-033 Clamp: with the same table, index -5 -> 0; index 1023 -> 508; index 254 -> 508.
REQ-034 Contention: req0 and req1 both valid for 4 cycles -> grants 0,1,0,1 with one response per cycle and correct data for each.
REQ-035 Reload: cfg_load_start during RUN while req0 is pending -> ready drops that cycle; the prior accept's response is still issued; after 255 new writes, lookups return the new values.
REQ-036 Before any load, or after reset, req0_valid = 1 -> req0_ready stays 0 and no rsp0_valid is produced; cfg_wen in IDLE does not alter the table.
REQ-037 Reset asserted after 100 load writes -> IDLE and table_valid = 0; a fresh cfg_load_start followed by 255 writes -> RUN.
